// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one 8N1 UART TX line between
// two byte requesters; every line change is paced by the baud tick.
module uart_tx_arbiter #(
    parameter int STOP_BITS = 1
) (
    input  logic       clk_24M,
    input  logic       reset,
    input  logic       baud_tick,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       tx,
    output logic       busy,
    output logic       grant_id,
    output logic       frame_done
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    localparam logic STOP_LAST = 1'(STOP_BITS - 1);

    state_t     r_state, w_state_nx;
    logic [7:0] r_shift, w_shift_nx;
    logic [2:0] r_bit_cnt, w_bit_cnt_nx;
    logic       r_stop_cnt, w_stop_cnt_nx;
    logic       r_tx, w_tx_nx;
    logic       r_busy, w_busy_nx;
    logic       r_grant, w_grant_nx;
    logic       r_last, w_last_nx;
    logic       r_done, w_done_nx;
    logic       w_pick1;
    logic       w_accept;

    // On a tie the requester that was not served last wins.
    assign w_pick1 = req1_valid && (!req0_valid || !r_last);
    assign w_accept = (r_state == S_IDLE) && !reset
                   && (req0_valid || req1_valid);

    assign req0_ready = w_accept && !w_pick1;
    assign req1_ready = w_accept && w_pick1;
    assign tx         = r_tx;
    assign busy       = r_busy;
    assign grant_id   = r_grant;
    assign frame_done = r_done;

    // Next-state and registered-output logic; line moves only on a tick.
    always_comb begin
        w_state_nx    = r_state;
        w_shift_nx    = r_shift;
        w_bit_cnt_nx  = r_bit_cnt;
        w_stop_cnt_nx = r_stop_cnt;
        w_tx_nx       = r_tx;
        w_busy_nx     = r_busy;
        w_grant_nx    = r_grant;
        w_last_nx     = r_last;
        w_done_nx     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_shift_nx = w_pick1 ? req1_data : req0_data;
                    w_grant_nx = w_pick1;
                    w_last_nx  = w_pick1;
                    w_busy_nx  = 1'b1;
                    w_state_nx = S_ALIGN;
                end
            end
            S_ALIGN: begin
                if (baud_tick) begin
                    w_tx_nx    = 1'b0;
                    w_state_nx = S_START;
                end
            end
            S_START: begin
                if (baud_tick) begin
                    w_tx_nx      = r_shift[0];
                    w_shift_nx   = {1'b0, r_shift[7:1]};
                    w_bit_cnt_nx = 3'd0;
                    w_state_nx   = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_tick) begin
                    w_bit_cnt_nx = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        w_tx_nx       = 1'b1;
                        w_stop_cnt_nx = 1'b0;
                        w_state_nx    = S_STOP;
                    end else begin
                        w_tx_nx    = r_shift[0];
                        w_shift_nx = {1'b0, r_shift[7:1]};
                    end
                end
            end
            S_STOP: begin
                if (baud_tick) begin
                    if (r_stop_cnt == STOP_LAST) begin
                        w_busy_nx  = 1'b0;
                        w_done_nx  = 1'b1;
                        w_state_nx = S_IDLE;
                    end else begin
                        w_stop_cnt_nx = r_stop_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // State register; reset aborts any frame and parks the line at mark.
    always_ff @(posedge clk_24M) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_shift    <= 8'd0;
            r_bit_cnt  <= 3'd0;
            r_stop_cnt <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_grant    <= 1'b0;
            r_last     <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_shift    <= w_shift_nx;
            r_bit_cnt  <= w_bit_cnt_nx;
            r_stop_cnt <= w_stop_cnt_nx;
            r_tx       <= w_tx_nx;
            r_busy     <= w_busy_nx;
            r_grant    <= w_grant_nx;
            r_last     <= w_last_nx;
            r_done     <= w_done_nx;
        end
    end
endmodule
